// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, N combinational read ports, optional zero register, write bypass and per-register pending bits
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we0,
  input  logic [AW-1:0]            waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [AW-1:0]            waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend
);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wv0, wv1, rv;
  // Address names a real, writable register (in range and not the hardwired zero).
  function automatic logic ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
  endfunction
  assign wv0 = we0 && ok(waddr0);
  assign wv1 = we1 && ok(waddr1);
  assign rv  = rsv_en && ok(rsv_addr);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      pending <= '0;
    end else begin
      if (wv0) mem[waddr0] <= wdata0;
      if (wv1) mem[waddr1] <= wdata1;
      for (int r = 0; r < DEPTH; r++)
        pending[r] <= (rv && rsv_addr == AW'(r)) ? 1'b1 :
                      ((wv0 && waddr0 == AW'(r)) || (wv1 && waddr1 == AW'(r))) ? 1'b0 : pending[r];
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          live, b0, b1;
    assign a    = rd_addr[i*AW +: AW];
    assign live = reset_n && ok(a);
    assign b1   = BYPASS != 0 && wv1 && waddr1 == a;
    assign b0   = BYPASS != 0 && wv0 && waddr0 == a;
    assign rd_data[i*DATA_W +: DATA_W] = !live ? '0 : b1 ? wdata1 : b0 ? wdata0 : mem[a];
    assign rd_pend[i] = live && !b1 && !b0 && pending[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp across bypass, zero-register and non-power-of-two depth builds
module tb_regfile_mp;
  logic       clk = 0, reset_n = 0;
  logic       we0 = 0, we1 = 0, rsv_en = 0;
  logic [3:0] waddr0 = 0, waddr1 = 0, rsv_addr = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic [7:0] rd_addr = 0;
  logic [15:0] rda, rdb, rdc;
  logic [1:0]  rpa, rpb, rpc;
  int passed = 0, total = 0;

  typedef struct {string name; int inst; int port; logic [7:0] d; logic p;} exp_t;
  exp_t q[$];
  event ev;

  always #5 clk = ~clk;

  regfile_mp dut_a (.clk(clk), .reset_n(reset_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rda), .rd_pend(rpa));
  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .reset_n(reset_n), .we0(we0),
    .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr), .rd_data(rdb), .rd_pend(rpb));
  regfile_mp #(.DEPTH(12)) dut_c (.clk(clk), .reset_n(reset_n), .we0(we0), .waddr0(waddr0),
    .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rd_addr(rd_addr), .rd_data(rdc), .rd_pend(rpc));

  initial forever begin
    exp_t e;
    logic [15:0] ad;
    logic [1:0]  ap;
    @(ev);
    while (q.size() > 0) begin
      e  = q.pop_front();
      ad = e.inst == 0 ? rda : e.inst == 1 ? rdb : rdc;
      ap = e.inst == 0 ? rpa : e.inst == 1 ? rpb : rpc;
      total++;
      if (ad[e.port*8 +: 8] === e.d) passed++;
      else $display("FAIL %s data inst%0d port%0d got %h want %h", e.name, e.inst, e.port, ad[e.port*8 +: 8], e.d);
      total++;
      if (ap[e.port] === e.p) passed++;
      else $display("FAIL %s pend inst%0d port%0d got %b want %b", e.name, e.inst, e.port, ap[e.port], e.p);
    end
  end

  task automatic exp(input string n, input int inst, input int port, input logic [7:0] d, input logic p);
    q.push_back('{n, inst, port, d, p});
  endtask

  task automatic sample();
    #2 -> ev;
    #0;
  endtask

  task automatic cyc();
    @(negedge clk);
    {we0, we1, rsv_en} = 3'b000;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [7:0] d);
    we0 = 1; waddr0 = a; wdata0 = d;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [7:0] d);
    we1 = 1; waddr1 = a; wdata1 = d;
  endtask

  task automatic rsv(input logic [3:0] a);
    rsv_en = 1; rsv_addr = a;
  endtask

  initial begin
    cyc(); rd_addr = 8'h33;
    exp("reset", 0, 0, 8'h00, 0); exp("reset", 0, 1, 8'h00, 0); sample();
    reset_n = 1;
    cyc(); wr0(3, 8'h10);
    cyc(); wr0(3, 8'hA5); wr1(3, 8'h5A); rd_addr = 8'h03;
    exp("wcollide_byp", 0, 0, 8'h5A, 0); exp("wcollide_old", 1, 0, 8'h10, 0); sample();
    cyc();
    exp("wcollide_post", 0, 0, 8'h5A, 0); exp("wcollide_post", 1, 0, 8'h5A, 0); sample();
    cyc(); wr0(0, 8'hFF); rsv(0); rd_addr = 8'h00;
    exp("zero_pre", 0, 0, 8'h00, 0); exp("zero_pre", 1, 0, 8'h00, 0); sample();
    cyc();
    exp("zero_reg", 0, 0, 8'h00, 0); exp("nozero_reg", 1, 0, 8'hFF, 1); exp("zero_reg", 2, 0, 8'h00, 0); sample();
    cyc(); rsv(7); rd_addr = 8'h07;
    exp("rsv7_pre", 0, 0, 8'h00, 0); sample();
    cyc(); exp("rsv7_n1", 0, 0, 8'h00, 1); sample();
    cyc(); exp("rsv7_n2", 0, 0, 8'h00, 1); sample();
    cyc(); wr1(7, 8'h3C);
    exp("w7_byp", 0, 0, 8'h3C, 0); exp("w7_nobyp", 1, 0, 8'h00, 1); sample();
    cyc();
    exp("w7_post", 0, 0, 8'h3C, 0); exp("w7_post", 1, 0, 8'h3C, 0); sample();
    cyc(); rsv(2); wr0(2, 8'h11); rd_addr = 8'h27;
    exp("rsvw2_pre", 0, 1, 8'h11, 0); exp("rsvw2_pre", 1, 1, 8'h00, 0); sample();
    cyc();
    exp("rsvw2_post", 0, 1, 8'h11, 1); exp("rsvw2_post", 1, 1, 8'h11, 1); sample();
    cyc(); rsv(4); rd_addr = 8'h47;
    cyc(); rsv(4);
    exp("rsv4_twice", 0, 1, 8'h00, 1); sample();
    cyc(); wr0(4, 8'h44);
    exp("w4_byp", 0, 1, 8'h44, 0); exp("w4_nobyp", 1, 1, 8'h00, 1); sample();
    cyc();
    exp("w4_clr", 0, 1, 8'h44, 0); exp("w4_clr", 1, 1, 8'h44, 0); sample();
    cyc(); wr0(8, 8'h81); wr1(9, 8'h92); rd_addr = 8'h98;
    cyc();
    exp("dual_w0", 0, 0, 8'h81, 0); exp("dual_w1", 0, 1, 8'h92, 0);
    exp("dual_w0", 1, 0, 8'h81, 0); exp("dual_w1", 1, 1, 8'h92, 0); sample();
    cyc(); wr0(13, 8'h77); rsv(13); rd_addr = 8'h3D;
    exp("oor_pre", 2, 0, 8'h00, 0); exp("oor_keep", 2, 1, 8'h5A, 0); exp("r13_byp", 0, 0, 8'h77, 0); sample();
    cyc();
    exp("oor_post", 2, 0, 8'h00, 0); exp("oor_keep", 2, 1, 8'h5A, 0);
    exp("r13_post", 0, 0, 8'h77, 1); exp("r3_live", 0, 1, 8'h5A, 0); sample();
    cyc(); rd_addr = 8'h23; reset_n = 0; wr0(3, 8'hEE);
    exp("async_rst", 0, 0, 8'h00, 0); exp("async_rst", 0, 1, 8'h00, 0); exp("async_rst", 1, 1, 8'h00, 0); sample();
    reset_n = 1; we0 = 0; rd_addr = 8'h35;
    exp("rst_rel_r5", 0, 0, 8'h00, 0); exp("rst_rel_r3", 0, 1, 8'h00, 0); exp("rst_rel_r3", 1, 1, 8'h00, 0); sample();
    cyc(); #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
